// File: rtl/mos6502s_alu_issue.sv
// mos6502s_alu_issue: ALU issue/writeback sequencer owning P; MOS6502S_DECIMAL_EN enables BCD via alu_d_flag
module mos6502s_alu_issue #(
   parameter logic [7:0] P_RESET = 8'h24
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [1:0] req_kind,
   input  logic [3:0] req_op,
   input  logic [7:0] req_a,
   input  logic [7:0] req_b,
   output logic [3:0] alu_op,
   output logic [7:0] alu_a,
   output logic [7:0] alu_b,
   output logic       alu_c_in,
   output logic       alu_d_flag,
   input  logic [7:0] alu_result,
   input  logic       alu_n,
   input  logic       alu_z,
   input  logic       alu_c,
   input  logic       alu_v,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [7:0] rsp_result,
   output logic [7:0] rsp_p,
   output logic [7:0] p_out
);
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
   state_t state_q, state_d;
   logic [7:0] p_q, p_d, rsp_result_q, rsp_result_d, rsp_p_q, rsp_p_d;
   logic [7:0] alu_a_q, alu_b_q, mask, flags, set_mask, raw, p_set, p_exec;
   logic [3:0] alu_op_q;
   logic       alu_c_in_q, issue;
   assign flags    = {alu_n, alu_v, 4'b0000, alu_z, alu_c};
   assign set_mask = req_b & 8'hCF;
   assign raw      = req_kind == 2'd1 ? req_a : (p_q & ~set_mask) | (set_mask & {8{req_a[0]}});
   assign p_set    = (raw & 8'hCF) | 8'h20;
   assign p_exec   = (((p_q & ~mask) | (flags & mask)) & 8'hCF) | 8'h20;
   // per-op flag write mask (N V - - - - Z C)
   always_comb begin
      case (alu_op_q)
         4'd0, 4'd1:                                mask = 8'hC3;
         4'd2, 4'd3, 4'd4, 4'd9, 4'd10, 4'd13:      mask = 8'h82;
         4'd5, 4'd6, 4'd7, 4'd8, 4'd11:             mask = 8'h83;
         4'd12:                                     mask = 8'hC2;
         4'd15:                                     mask = 8'h01;
         default:                                   mask = 8'h00;
      endcase
   end
   // next state, P writeback and response capture
   always_comb begin
      state_d      = state_q;
      p_d          = p_q;
      rsp_result_d = rsp_result_q;
      rsp_p_d      = rsp_p_q;
      issue        = 1'b0;
      case (state_q)
         IDLE: if (req_valid) begin
            if (req_kind == 2'd0) begin
               issue   = 1'b1;
               state_d = EXEC;
            end else begin
               p_d          = p_set;
               rsp_result_d = p_set;
               rsp_p_d      = p_set;
               state_d      = RESP;
            end
         end
         EXEC: begin
            p_d          = p_exec;
            rsp_result_d = alu_result;
            rsp_p_d      = p_exec;
            state_d      = RESP;
         end
         RESP: state_d = rsp_ready ? IDLE : RESP;
         default: state_d = IDLE;
      endcase
   end
   // state, P, response and ALU input registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         p_q          <= P_RESET;
         rsp_result_q <= 8'h00;
         rsp_p_q      <= P_RESET;
         alu_op_q     <= 4'h0;
         alu_a_q      <= 8'h00;
         alu_b_q      <= 8'h00;
         alu_c_in_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         p_q          <= p_d;
         rsp_result_q <= rsp_result_d;
         rsp_p_q      <= rsp_p_d;
         if (issue) begin
            alu_op_q   <= req_op;
            alu_a_q    <= req_a;
            alu_b_q    <= req_b;
            alu_c_in_q <= p_q[0];
         end
      end
   end
`ifdef MOS6502S_DECIMAL_EN
   logic alu_d_q;
   // decimal mode sampled from P.D at issue
   always_ff @(posedge clk) begin
      if (rst) alu_d_q <= 1'b0;
      else if (issue) alu_d_q <= p_q[3];
   end
   assign alu_d_flag = alu_d_q;
`else
   assign alu_d_flag = 1'b0;
`endif
   assign req_ready  = state_q == IDLE;
   assign rsp_valid  = state_q == RESP;
   assign rsp_result = rsp_result_q;
   assign rsp_p      = rsp_p_q;
   assign p_out      = p_q;
   assign alu_op     = alu_op_q;
   assign alu_a      = alu_a_q;
   assign alu_b      = alu_b_q;
   assign alu_c_in   = alu_c_in_q;
endmodule

// File: tb/tb_mos6502s_alu_issue.sv
// tb_mos6502s_alu_issue: scoreboard bench with a behavioural ALU stand-in
module tb_mos6502s_alu_issue;
`ifdef MOS6502S_DECIMAL_EN
   localparam bit DEC = 1'b1;
`else
   localparam bit DEC = 1'b0;
`endif
   logic       clk = 1'b0, rst = 1'b1, req_valid = 1'b0, rsp_ready = 1'b1;
   logic [1:0] req_kind = 2'd0;
   logic [3:0] req_op = 4'd0;
   logic [7:0] req_a = 8'h00, req_b = 8'h00;
   logic       req_ready, alu_c_in, alu_d_flag, rsp_valid;
   logic [3:0] alu_op;
   logic [7:0] alu_a, alu_b, rsp_result, rsp_p, p_out;
   logic [7:0] alu_result;
   logic       alu_n, alu_z, alu_c, alu_v;
   typedef struct {int res; int p; int lat; int acc;} exp_t;
   exp_t sb[$];
   int tests = 0, fails = 0, cyc = 0;
   bit seen = 1'b0;
   logic [7:0] tb_p = 8'h24;

   mos6502s_alu_issue dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_kind(req_kind), .req_op(req_op), .req_a(req_a), .req_b(req_b),
      .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_c_in(alu_c_in),
      .alu_d_flag(alu_d_flag), .alu_result(alu_result), .alu_n(alu_n),
      .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v), .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_p(rsp_p), .p_out(p_out)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ALU stand-in: ADC (op0, with BCD), CMP (op11), BIT (op12), others XOR
   int lo, hi;
   logic [8:0] s;
   always_comb begin
      s = 9'(alu_a) + 9'(alu_b) + 9'(alu_c_in);
      lo = 0;
      hi = 0;
      alu_result = alu_a ^ alu_b;
      alu_c = alu_a[0];
      alu_v = alu_a[6];
      if (alu_op == 4'd0) begin
         alu_result = s[7:0];
         alu_c = s[8];
         alu_v = ~(alu_a[7] ^ alu_b[7]) & (alu_a[7] ^ s[7]);
         if (alu_d_flag) begin
            lo = int'(alu_a[3:0]) + int'(alu_b[3:0]) + int'(alu_c_in);
            if (lo > 9) lo = lo + 6;
            hi = int'(alu_a[7:4]) + int'(alu_b[7:4]) + (lo > 15 ? 1 : 0);
            if (hi > 9) hi = hi + 6;
            alu_result = {hi[3:0], lo[3:0]};
            alu_c = hi > 15;
         end
      end else if (alu_op == 4'd11) begin
         alu_result = alu_a - alu_b;
         alu_c = alu_a >= alu_b;
         alu_v = 1'b1;
      end else if (alu_op == 4'd12) begin
         alu_result = alu_a;
         alu_v = alu_b[6];
      end
      alu_n = alu_op == 4'd12 ? alu_b[7] : alu_result[7];
      alu_z = alu_op == 4'd12 ? (alu_a & alu_b) == 8'h00 : alu_result == 8'h00;
   end

   task automatic chk(input string nm, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // monitor: latency on first sight of a response, payload on handshake
   always @(negedge clk) begin
      if (rst) seen = 1'b0;
      else if (rsp_valid) begin
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL spurious_rsp: got result=%0h p=%0h, expected no response", rsp_result, rsp_p);
         end else begin
            if (!seen) begin
               chk("latency", cyc - sb[0].acc, sb[0].lat);
               seen = 1'b1;
            end
            if (rsp_ready) begin
               chk("rsp_result", int'(rsp_result), sb[0].res);
               chk("rsp_p", int'(rsp_p), sb[0].p);
               void'(sb.pop_front());
               seen = 1'b0;
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [1:0] k, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] res, input logic [7:0] p);
      int n = 0;
      while (!req_ready && n < 50) begin
         step();
         n++;
      end
      if (!req_ready) begin
         chk("req_ready_timeout", 0, 1);
         return;
      end
      req_valid = 1'b1;
      req_kind = k;
      req_op = op;
      req_a = a;
      req_b = b;
      sb.push_back('{int'(res), int'(p), k == 2'd0 ? 2 : 1, cyc});
      step();
      req_valid = 1'b0;
      if (k == 2'd0) begin
         chk("alu_op", int'(alu_op), int'(op));
         chk("alu_a", int'(alu_a), int'(a));
         chk("alu_b", int'(alu_b), int'(b));
         chk("alu_c_in", int'(alu_c_in), int'(tb_p[0]));
         chk("alu_d_flag", int'(alu_d_flag), DEC ? int'(tb_p[3]) : 0);
      end
      tb_p = p;
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 50) begin
         step();
         n++;
      end
      chk("drain", sb.size(), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_p_out", int'(p_out), 'h24);
      chk("rst_rsp_p", int'(rsp_p), 'h24);
      chk("rst_rsp_result", int'(rsp_result), 0);
      chk("rst_rsp_valid", int'(rsp_valid), 0);
      chk("rst_req_ready", int'(req_ready), 1);
      chk("rst_alu_op", int'(alu_op), 0);
      chk("rst_alu_a", int'(alu_a), 0);
      chk("rst_alu_b", int'(alu_b), 0);
      chk("rst_alu_c_in", int'(alu_c_in), 0);
      chk("rst_alu_d", int'(alu_d_flag), 0);
      rst = 1'b0;
      issue(2'd0, 4'd0,  8'h50, 8'h50, 8'hA0, 8'hE4);
      issue(2'd2, 4'd0,  8'h01, 8'h08, 8'hEC, 8'hEC);
      issue(2'd0, 4'd0,  8'h09, 8'h01, DEC ? 8'h10 : 8'h0A, 8'h2C);
      issue(2'd0, 4'd11, 8'h10, 8'h10, 8'h00, 8'h2F);
      issue(2'd0, 4'd12, 8'h0F, 8'hC0, 8'h0F, 8'hEF);
      issue(2'd1, 4'd0,  8'hFF, 8'h00, 8'hEF, 8'hEF);
      issue(2'd2, 4'd0,  8'h00, 8'hFF, 8'h20, 8'h20);
      issue(2'd3, 4'd0,  8'h01, 8'h31, 8'h21, 8'h21);
      issue(2'd0, 4'd15, 8'hC0, 8'h40, 8'h80, 8'h20);
      issue(2'd0, 4'd14, 8'hC1, 8'h41, 8'h80, 8'h20);
      issue(2'd0, 4'd2,  8'h41, 8'h41, 8'h00, 8'h22);
      drain();
      chk("p_out_after_ops", int'(p_out), 'h22);
      rsp_ready = 1'b0;
      issue(2'd0, 4'd0, 8'h01, 8'h01, 8'h02, 8'h20);
      for (int n = 0; n < 10 && !rsp_valid; n++) step();
      for (int i = 0; i < 5; i++) begin
         req_valid = 1'b1;
         req_kind = 2'd1;
         req_a = 8'hFF;
         step();
         chk("bp_rsp_valid", int'(rsp_valid), 1);
         chk("bp_req_ready", int'(req_ready), 0);
         chk("bp_rsp_result", int'(rsp_result), 'h02);
         chk("bp_rsp_p", int'(rsp_p), 'h20);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      drain();
      chk("bp_p_out", int'(p_out), 'h20);
      chk("bp_idle", int'(req_ready), 1);
      req_valid = 1'b1;
      req_kind = 2'd0;
      req_op = 4'd0;
      req_a = 8'hFF;
      req_b = 8'h01;
      step();
      req_valid = 1'b0;
      chk("abort_in_exec", int'(req_ready), 0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      tb_p = 8'h24;
      chk("abort_p_out", int'(p_out), 'h24);
      chk("abort_rsp_valid", int'(rsp_valid), 0);
      chk("abort_req_ready", int'(req_ready), 1);
      chk("abort_rsp_p", int'(rsp_p), 'h24);
      repeat (3) begin
         step();
         chk("abort_no_rsp", int'(rsp_valid), 0);
      end
      issue(2'd0, 4'd0, 8'hFF, 8'h01, 8'h00, 8'h27);
      drain();
      chk("final_p_out", int'(p_out), 'h27);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
